hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl_if.sv | 25 ++
 rtl/hex_display_ctrl.sv | 119 +++++++++++
 tb/tb_hex_display_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_ctrl_if.sv
// Message load channel for the hex display controller.
// Requester drives the message; controller returns ready.
interface hex_display_ctrl_if;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_mode;
   logic        blank_lz;

   modport master (
      output load_valid,
      output load_data,
      output load_mode,
      output blank_lz,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_mode,
      input  blank_lz,
      output load_ready
   );
endinterface

// File: rtl/hex_display_ctrl.sv
// Six-digit hex display controller: static view with leading-zero
// blanking, or an MSB-first scroll of an 8-nibble message.
module hex_display_ctrl #(
   parameter logic [31:0] DIV = 32'd25000000
) (
   input  logic               clk,
   input  logic               reset,
   hex_display_ctrl_if.slave  ld,
   output logic [23:0]        digits,
   output logic [5:0]         digit_on,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      IDLE,
      STATIC,
      SCROLL
   } state_t;

   localparam logic [31:0] LAST = DIV - 32'd1;

   state_t      r_state;
   logic [31:0] r_msg;
   logic [31:0] r_tick;
   logic [3:0]  r_step;
   logic [23:0] r_digits;
   logic [5:0]  r_on;
   logic        r_busy;
   logic        r_done;
   logic        r_ready;

   logic        w_xfer;
   logic        w_last;
   logic [3:0]  w_next_step;
   logic [3:0]  w_step_nib;
   logic        w_step_on;
   logic [5:0]  w_lz_on;

   assign w_xfer      = ld.load_valid && r_ready;
   assign w_last      = (r_tick == LAST);
   assign w_next_step = r_step + 4'd1;
   // Steps 1..8 feed message nibbles 7..0; later steps feed blanks.
   assign w_step_nib  = r_step[3] ? 4'h0
                      : r_msg[{~r_step[2:0], 2'b00} +: 4];
   assign w_step_on   = ~r_step[3];

   // Digit i stays lit unless it and everything above it is zero.
   always_comb begin
      w_lz_on    = 6'b111111;
      for (int i = 1; i < 6; i++) begin
         w_lz_on[i] = ~ld.blank_lz
                    | (|(ld.load_data[23:0] >> (4 * i)));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_msg    <= '0;
         r_tick   <= '0;
         r_step   <= '0;
         r_digits <= '0;
         r_on     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, STATIC: begin
               if (w_xfer && !ld.load_mode) begin
                  r_state  <= STATIC;
                  r_digits <= ld.load_data[23:0];
                  r_on     <= w_lz_on;
               end else if (w_xfer) begin
                  r_state  <= SCROLL;
                  r_msg    <= ld.load_data;
                  r_digits <= '0;
                  r_on     <= '0;
                  r_busy   <= 1'b1;
                  r_ready  <= 1'b0;
                  r_tick   <= '0;
                  r_step   <= '0;
               end
            end
            SCROLL: begin
               if (w_last) begin
                  r_tick   <= '0;
                  r_step   <= w_next_step;
                  r_digits <= {r_digits[19:0], w_step_nib};
                  r_on     <= {r_on[4:0], w_step_on};
                  if (w_next_step == 4'd14) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_ready <= 1'b1;
                  end
               end else begin
                  r_tick <= r_tick + 32'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_on    <= '0;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ld.load_ready = r_ready;
   assign digits        = r_digits;
   assign digit_on      = r_on;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench: DIV=4 instance for static/scroll/reset cases,
// DIV=1 instance for the back-to-back scroll then static case.
module tb_hex_display_ctrl;

   logic        clk;
   logic        reset;
   logic [23:0] d4, d1;
   logic [5:0]  on4, on1;
   logic        busy4, busy1;
   logic        done4, done1;
   int          checks;
   int          errors;
   logic        seen;

   hex_display_ctrl_if if4 ();
   hex_display_ctrl_if if1 ();

   hex_display_ctrl #(.DIV(32'd4)) u4 (
      .clk      (clk),
      .reset    (reset),
      .ld       (if4.slave),
      .digits   (d4),
      .digit_on (on4),
      .busy     (busy4),
      .done     (done4)
   );

   hex_display_ctrl #(.DIV(32'd1)) u1 (
      .clk      (clk),
      .reset    (reset),
      .ld       (if1.slave),
      .digits   (d1),
      .digit_on (on1),
      .busy     (busy1),
      .done     (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      seen   = 1'b0;
      reset  = 1'b1;
      if4.load_valid = 1'b0;
      if4.load_data  = '0;
      if4.load_mode  = 1'b0;
      if4.blank_lz   = 1'b0;
      if1.load_valid = 1'b0;
      if1.load_data  = '0;
      if1.load_mode  = 1'b0;
      if1.blank_lz   = 1'b0;

      // reset state
      cyc();
      reset = 1'b0;
      chk("rst_digits", 32'(d4), 32'h0);
      chk("rst_on", 32'(on4), 32'h0);
      chk("rst_busy", 32'(busy4), 32'h0);
      chk("rst_done", 32'(done4), 32'h0);
      chk("rst_ready", 32'(if4.load_ready), 32'h1);

      // static, blanking on: digits 000A05 -> three lit digits
      if4.load_valid = 1'b1;
      if4.load_data  = 32'h00000A05;
      if4.load_mode  = 1'b0;
      if4.blank_lz   = 1'b1;
      cyc();
      if4.load_valid = 1'b0;
      chk("st_a05_digits", 32'(d4), 32'h000A05);
      chk("st_a05_on", 32'(on4), 32'h07);
      chk("st_a05_done", 32'(done4), 32'h0);
      chk("st_a05_ready", 32'(if4.load_ready), 32'h1);

      // same value, blanking off
      if4.load_valid = 1'b1;
      if4.blank_lz   = 1'b0;
      cyc();
      if4.load_valid = 1'b0;
      chk("st_a05_nolz_on", 32'(on4), 32'h3F);

      // all zero with blanking keeps digit 0 lit
      if4.load_valid = 1'b1;
      if4.load_data  = 32'h00000000;
      if4.blank_lz   = 1'b1;
      cyc();
      if4.load_valid = 1'b0;
      chk("st_zero_digits", 32'(d4), 32'h0);
      chk("st_zero_on", 32'(on4), 32'h01);

      // upper two nibbles are discarded
      if4.load_valid = 1'b1;
      if4.load_data  = 32'hFF000001;
      cyc();
      if4.load_valid = 1'b0;
      chk("st_trunc_digits", 32'(d4), 32'h000001);
      chk("st_trunc_on", 32'(on4), 32'h01);
      cyc();
      chk("st_hold_digits", 32'(d4), 32'h000001);

      // DIV=4 scroll with a competing request held high
      if4.load_valid = 1'b1;
      if4.load_data  = 32'h12345678;
      if4.load_mode  = 1'b1;
      if4.blank_lz   = 1'b1;
      cyc();
      if4.load_data  = 32'hDEADBEEF;
      if4.load_mode  = 1'b0;
      if4.blank_lz   = 1'b0;
      chk("sc_start_busy", 32'(busy4), 32'h1);
      chk("sc_start_ready", 32'(if4.load_ready), 32'h0);
      chk("sc_start_digits", 32'(d4), 32'h0);
      chk("sc_start_on", 32'(on4), 32'h0);
      for (int k = 1; k <= 56; k++) begin
         cyc();
         chk($sformatf("sc_done_%0d", k), 32'(done4), 32'(k == 56));
         chk($sformatf("sc_busy_%0d", k), 32'(busy4), 32'(k != 56));
         if (k == 3) chk("sc_c3_digits", 32'(d4), 32'h0);
         if (k == 4) begin
            chk("sc_c4_digits", 32'(d4), 32'h000001);
            chk("sc_c4_on", 32'(on4), 32'h01);
         end
         if (k == 24) begin
            chk("sc_s6_digits", 32'(d4), 32'h123456);
            chk("sc_s6_on", 32'(on4), 32'h3F);
            chk("sc_s6_ready", 32'(if4.load_ready), 32'h0);
         end
         if (k == 32) chk("sc_s8_digits", 32'(d4), 32'h345678);
         if (k == 56) begin
            chk("sc_end_digits", 32'(d4), 32'h0);
            chk("sc_end_on", 32'(on4), 32'h0);
            chk("sc_end_ready", 32'(if4.load_ready), 32'h1);
         end
      end
      // pending request transfers on the first idle cycle
      cyc();
      if4.load_valid = 1'b0;
      chk("pend_digits", 32'(d4), 32'hADBEEF);
      chk("pend_on", 32'(on4), 32'h3F);
      chk("pend_done", 32'(done4), 32'h0);
      chk("pend_busy", 32'(busy4), 32'h0);

      // reset at scroll step 5
      if4.load_valid = 1'b1;
      if4.load_data  = 32'h12345678;
      if4.load_mode  = 1'b1;
      cyc();
      if4.load_valid = 1'b0;
      repeat (20) cyc();
      chk("ab_s5_digits", 32'(d4), 32'h012345);
      chk("ab_s5_on", 32'(on4), 32'h1F);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("ab_digits", 32'(d4), 32'h0);
      chk("ab_on", 32'(on4), 32'h0);
      chk("ab_busy", 32'(busy4), 32'h0);
      chk("ab_done", 32'(done4), 32'h0);
      chk("ab_ready", 32'(if4.load_ready), 32'h1);
      seen = 1'b0;
      repeat (70) begin
         cyc();
         if (done4 || busy4) seen = 1'b1;
      end
      chk("ab_no_done", 32'(seen), 32'h0);

      // reset wins over a simultaneous transfer
      if4.load_valid = 1'b1;
      if4.load_data  = 32'h00000777;
      if4.load_mode  = 1'b0;
      if4.blank_lz   = 1'b0;
      cyc();
      chk("pri_pre_digits", 32'(d4), 32'h000777);
      if4.load_data  = 32'h00000123;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      if4.load_valid = 1'b0;
      chk("pri_digits", 32'(d4), 32'h0);
      chk("pri_on", 32'(on4), 32'h0);
      cyc();
      chk("pri_hold_digits", 32'(d4), 32'h0);

      // DIV=1 scroll then static load right after done
      if1.load_valid = 1'b1;
      if1.load_data  = 32'hABCDEF01;
      if1.load_mode  = 1'b1;
      cyc();
      if1.load_valid = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         cyc();
         chk($sformatf("d1_done_%0d", k), 32'(done1), 32'(k == 14));
         if (k == 1) begin
            chk("d1_s1_digits", 32'(d1), 32'h00000A);
            chk("d1_s1_on", 32'(on1), 32'h01);
         end
         if (k == 8) begin
            chk("d1_s8_digits", 32'(d1), 32'hCDEF01);
            chk("d1_s8_on", 32'(on1), 32'h3F);
         end
         if (k == 13) chk("d1_s13_busy", 32'(busy1), 32'h1);
         if (k == 14) begin
            chk("d1_end_digits", 32'(d1), 32'h0);
            chk("d1_end_busy", 32'(busy1), 32'h0);
            chk("d1_end_ready", 32'(if1.load_ready), 32'h1);
         end
      end
      if1.load_valid = 1'b1;
      if1.load_data  = 32'h00000042;
      if1.load_mode  = 1'b0;
      if1.blank_lz   = 1'b1;
      cyc();
      if1.load_valid = 1'b0;
      chk("d1_st_digits", 32'(d1), 32'h000042);
      chk("d1_st_on", 32'(on1), 32'h03);
      chk("d1_st_done", 32'(done1), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
